// File: rtl/axil_axi_adapter_wr_if.sv
// Bus interfaces for the AXI4-Lite to AXI4 write-path adapter.
//
// axil_wr_if : AXI4-Lite write channels (AW, W, B).
//              master drives awaddr/awprot/awvalid, wdata/wstrb/wvalid, bready;
//              slave drives awready, wready, bresp/bvalid.
// axi_wr_if  : AXI4 write channels (AW, W, B) as used by a single-beat writer.
//              master drives the AW and W payloads, their valids, and bready;
//              slave drives awready, wready, bid/bresp/bvalid.

interface axil_wr_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

interface axi_wr_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axil_axi_adapter_wr.sv
// AXI4-Lite to AXI4 write-path adapter.
//
// Accepts one Lite write (AW and W in any order) on s_axil, issues it as a
// single-beat INCR write on m_axi with the Lite data replicated across the
// wider AXI bus and the strobes placed in the addressed lane, then returns
// the AXI write response on the Lite B channel. One transaction at a time.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   s_axil : Lite write subordinate port (axil_wr_if.slave)
//   m_axi  : AXI4 write manager port (axi_wr_if.master)

module axil_axi_adapter_wr #(
    parameter int ADDR_WIDTH      = 32,
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_STRB_WIDTH  = AXI_DATA_WIDTH / 8,
    parameter int AXI_ID_WIDTH    = 8,
    parameter logic [AXI_ID_WIDTH-1:0] AXI_ID = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    axil_wr_if.slave   s_axil,
    axi_wr_if.master   m_axi
);

    localparam int RATIO      = AXI_STRB_WIDTH / AXIL_STRB_WIDTH;
    localparam int LANE_LSB   = $clog2(AXIL_STRB_WIDTH);
    localparam int LANE_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_B,
        RESP
    } state_t;

    state_t                     state;
    logic                       aw_done;
    logic                       w_done;
    logic [ADDR_WIDTH-1:0]      awaddr_q;
    logic [2:0]                 awprot_q;
    logic [AXIL_DATA_WIDTH-1:0] wdata_q;
    logic [AXIL_STRB_WIDTH-1:0] wstrb_q;
    logic                       s_awready_q;
    logic                       s_wready_q;
    logic                       s_bvalid_q;
    logic [1:0]                 s_bresp_q;
    logic                       m_awvalid_q;
    logic                       m_wvalid_q;
    logic                       m_bready_q;
    logic                       aw_hs;
    logic                       w_hs;
    logic [LANE_WIDTH-1:0]      lane;

    assign aw_hs = s_awready_q && s_axil.awvalid;
    assign w_hs  = s_wready_q && s_axil.wvalid;

    // Each Lite ready is owned by its own capture flag so AW and W can land
    // in either order; the AXI valids go out together once both are held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            awaddr_q    <= '0;
            awprot_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            s_awready_q <= 1'b0;
            s_wready_q  <= 1'b0;
            s_bvalid_q  <= 1'b0;
            s_bresp_q   <= 2'b00;
            m_awvalid_q <= 1'b0;
            m_wvalid_q  <= 1'b0;
            m_bready_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        awaddr_q    <= s_axil.awaddr;
                        awprot_q    <= s_axil.awprot;
                        aw_done     <= 1'b1;
                        s_awready_q <= 1'b0;
                    end else if (!aw_done) begin
                        s_awready_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q    <= s_axil.wdata;
                        wstrb_q    <= s_axil.wstrb;
                        w_done     <= 1'b1;
                        s_wready_q <= 1'b0;
                    end else if (!w_done) begin
                        s_wready_q <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state       <= ISSUE;
                        m_awvalid_q <= 1'b1;
                        m_wvalid_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (m_axi.awready) begin
                        m_awvalid_q <= 1'b0;
                    end
                    if (m_axi.wready) begin
                        m_wvalid_q <= 1'b0;
                    end
                    // A channel counts as finished if it already dropped or completes now.
                    if ((!m_awvalid_q || m_axi.awready) && (!m_wvalid_q || m_axi.wready)) begin
                        state      <= WAIT_B;
                        m_bready_q <= 1'b1;
                    end
                end
                WAIT_B: begin
                    if (m_axi.bvalid && m_bready_q) begin
                        m_bready_q <= 1'b0;
                        s_bresp_q  <= (m_axi.bid == AXI_ID) ? m_axi.bresp : 2'b10;
                        s_bvalid_q <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (s_axil.bready) begin
                        s_bvalid_q  <= 1'b0;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        s_awready_q <= 1'b1;
                        s_wready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The Lite strobes land in the AXI lane selected by the address bits just
    // above the Lite byte offset; data is replicated so any lane sees it.
    generate
        if (RATIO > 1) begin : g_lane
            assign lane        = awaddr_q[LANE_LSB +: LANE_WIDTH];
            assign m_axi.wstrb = AXI_STRB_WIDTH'(wstrb_q) << (lane * AXIL_STRB_WIDTH);
        end else begin : g_no_lane
            assign lane        = '0;
            assign m_axi.wstrb = wstrb_q;
        end
    endgenerate

    assign m_axi.wdata   = {RATIO{wdata_q}};
    assign m_axi.awid    = AXI_ID;
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awlen   = 8'd0;
    assign m_axi.awsize  = 3'($clog2(AXIL_STRB_WIDTH));
    assign m_axi.awburst = 2'b01;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'b0011;
    assign m_axi.awprot  = awprot_q;
    assign m_axi.awvalid = m_awvalid_q;
    assign m_axi.wlast   = 1'b1;
    assign m_axi.wvalid  = m_wvalid_q;
    assign m_axi.bready  = m_bready_q;

    assign s_axil.awready = s_awready_q;
    assign s_axil.wready  = s_wready_q;
    assign s_axil.bresp   = s_bresp_q;
    assign s_axil.bvalid  = s_bvalid_q;

endmodule

// File: tb/tb_axil_axi_adapter_wr.sv
// Testbench for axil_axi_adapter_wr.
//
// Two adapters share the same stimulus: dut_n has a 32-bit AXI side (R=1),
// dut_w a 128-bit AXI side (R=4). Both see identical Lite inputs and AXI
// responses, so their handshake timing matches and only the lane-placed
// payload differs. Each table record carries the Lite write, the AXI peer
// behaviour and the expected results; the record is queued when the Lite
// write is driven and popped when the AXI write appears.

module tb_axil_axi_adapter_wr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    axil_wr_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) lite_n ();
    axil_wr_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) lite_w ();
    axi_wr_if  #(.ADDR_WIDTH(32), .DATA_WIDTH(32),  .ID_WIDTH(8)) axi_n ();
    axi_wr_if  #(.ADDR_WIDTH(32), .DATA_WIDTH(128), .ID_WIDTH(8)) axi_w ();

    axil_axi_adapter_wr #(
        .ADDR_WIDTH(32), .AXIL_DATA_WIDTH(32), .AXI_DATA_WIDTH(32),
        .AXI_ID_WIDTH(8), .AXI_ID(8'h00)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .s_axil(lite_n), .m_axi(axi_n)
    );

    axil_axi_adapter_wr #(
        .ADDR_WIDTH(32), .AXIL_DATA_WIDTH(32), .AXI_DATA_WIDTH(128),
        .AXI_ID_WIDTH(8), .AXI_ID(8'h00)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .s_axil(lite_w), .m_axi(axi_w)
    );

    // The wide adapter mirrors every bench-driven input of the narrow one.
    assign lite_w.awaddr  = lite_n.awaddr;
    assign lite_w.awprot  = lite_n.awprot;
    assign lite_w.awvalid = lite_n.awvalid;
    assign lite_w.wdata   = lite_n.wdata;
    assign lite_w.wstrb   = lite_n.wstrb;
    assign lite_w.wvalid  = lite_n.wvalid;
    assign lite_w.bready  = lite_n.bready;
    assign axi_w.awready  = axi_n.awready;
    assign axi_w.wready   = axi_n.wready;
    assign axi_w.bid      = axi_n.bid;
    assign axi_w.bresp    = axi_n.bresp;
    assign axi_w.bvalid   = axi_n.bvalid;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_gap;
        int          w_gap;
        int          aw_stall;
        logic [7:0]  bid;
        logic [1:0]  bresp;
        logic [1:0]  exp_bresp;
        logic [15:0] exp_wstrb_wide;
    } vec_t;

    localparam int NUM_VECS = 9;
    localparam int CYCLE_BUDGET = 60;

    vec_t vecs[NUM_VECS];
    vec_t sb_q[$];
    int   vec_count = 0;
    int   miss_count = 0;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        lite_n.awvalid = 1'b0;
        lite_n.wvalid  = 1'b0;
        lite_n.bready  = 1'b0;
        axi_n.awready  = 1'b0;
        axi_n.wready   = 1'b0;
        axi_n.bvalid   = 1'b0;
        axi_n.bid      = 8'h00;
        axi_n.bresp    = 2'b00;
    endtask

    // Runs one complete write, stepping on falling edges: outputs are sampled
    // there and inputs for the coming rising edge are driven there.
    task automatic apply_stimulus(input vec_t v);
        vec_t cur;
        bit   aw_done = 0, w_done = 0;
        bit   axi_started = 0, axi_aw_done = 0, axi_w_done = 0, b_done = 0;
        bit   finished = 0;
        bit   aw_hs, w_hs, m_aw_hs, m_w_hs, m_b_hs;
        int   lite_done_cyc = -1;
        int   aw_wait = 0;

        sb_q.push_back(v);
        cur = v;
        for (int c = 0; c < CYCLE_BUDGET && !finished; c++) begin
            @(negedge clk);
            lite_n.awaddr  = v.addr;
            lite_n.awprot  = v.data[2:0];
            lite_n.wdata   = v.data;
            lite_n.wstrb   = v.strb;
            lite_n.awvalid = (c >= v.aw_gap) && !aw_done;
            lite_n.wvalid  = (c >= v.w_gap) && !w_done;
            lite_n.bready  = 1'b1;

            if (aw_done) check_output("awready_lockout", lite_n.awready, 1'b0);
            if (w_done)  check_output("wready_lockout", lite_n.wready, 1'b0);
            aw_hs = lite_n.awvalid && lite_n.awready;
            w_hs  = lite_n.wvalid && lite_n.wready;

            if (!axi_started && (axi_n.awvalid || axi_n.wvalid)) begin
                axi_started = 1;
                check_output("issue_latency", c, lite_done_cyc + 1);
                check_output("awvalid_wvalid_together", {axi_n.awvalid, axi_n.wvalid}, 2'b11);
                if (sb_q.size() > 0) cur = sb_q.pop_front();
            end

            axi_n.awready = axi_n.awvalid && (aw_wait >= v.aw_stall);
            axi_n.wready  = 1'b1;
            if (axi_n.awvalid && !axi_n.awready) aw_wait++;
            if (axi_aw_done) check_output("awvalid_after_hs", axi_n.awvalid, 1'b0);
            if (axi_w_done)  check_output("wvalid_after_hs", axi_n.wvalid, 1'b0);
            if (axi_n.awvalid) check_output("awaddr_stable", axi_n.awaddr, cur.addr);
            check_output("bready_order", axi_n.bready && !(axi_aw_done && axi_w_done), 1'b0);

            m_aw_hs = axi_n.awvalid && axi_n.awready;
            m_w_hs  = axi_n.wvalid && axi_n.wready;
            if (m_aw_hs) begin
                check_output("awaddr", axi_n.awaddr, cur.addr);
                check_output("awprot", axi_n.awprot, cur.data[2:0]);
                check_output("aw_const", {axi_n.awid, axi_n.awlen, axi_n.awsize, axi_n.awburst,
                                          axi_n.awlock, axi_n.awcache},
                             {8'h00, 8'h00, 3'd2, 2'b01, 1'b0, 4'b0011});
                check_output("awaddr_wide", axi_w.awaddr, cur.addr);
                check_output("awsize_wide", axi_w.awsize, 3'd2);
            end
            if (m_w_hs) begin
                check_output("wdata", axi_n.wdata, cur.data);
                check_output("wstrb", axi_n.wstrb, cur.strb);
                check_output("wlast", axi_n.wlast, 1'b1);
                check_output("wvalid_wide", axi_w.wvalid, 1'b1);
                check_output("wdata_wide", axi_w.wdata, {4{cur.data}});
                check_output("wstrb_wide", axi_w.wstrb, cur.exp_wstrb_wide);
            end

            axi_n.bvalid = axi_aw_done && axi_w_done && !b_done;
            axi_n.bid    = v.bid;
            axi_n.bresp  = v.bresp;
            m_b_hs = axi_n.bvalid && axi_n.bready;

            if (lite_n.bvalid) begin
                check_output("s_bresp", lite_n.bresp, cur.exp_bresp);
                check_output("s_bresp_wide", lite_w.bresp, cur.exp_bresp);
                finished = 1;
            end

            if (aw_hs)   aw_done = 1;
            if (w_hs)    w_done = 1;
            if (m_aw_hs) axi_aw_done = 1;
            if (m_w_hs)  axi_w_done = 1;
            if (m_b_hs)  b_done = 1;
            if (aw_done && w_done && lite_done_cyc < 0) lite_done_cyc = c;
        end
        if (!finished) check_output("timeout", 1'b1, 1'b0);

        @(negedge clk);
        drive_idle();
        check_output("idle_awready", lite_n.awready, 1'b1);
        check_output("idle_wready", lite_n.wready, 1'b1);
        check_output("idle_bvalid", lite_n.bvalid, 1'b0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 8'h00, 2'b00, 2'b00, 16'h000F};
        vecs[1] = '{32'h0000_0008, 32'h1234_5678, 4'h3, 0, 0, 0, 8'h00, 2'b00, 2'b00, 16'h0300};
        vecs[2] = '{32'h0000_2004, 32'hCAFE_F00D, 4'hC, 3, 0, 0, 8'h00, 2'b00, 2'b00, 16'h00C0};
        vecs[3] = '{32'h0000_300C, 32'h0BAD_C0DE, 4'h0, 0, 2, 0, 8'h00, 2'b00, 2'b00, 16'h0000};
        vecs[4] = '{32'h0000_4000, 32'hA5A5_A5A5, 4'hF, 0, 0, 5, 8'h00, 2'b00, 2'b00, 16'h000F};
        vecs[5] = '{32'h0000_5010, 32'h1111_2222, 4'hF, 0, 0, 0, 8'h05, 2'b00, 2'b10, 16'h000F};
        vecs[6] = '{32'h0000_6018, 32'h3333_4444, 4'h6, 0, 0, 0, 8'h00, 2'b11, 2'b11, 16'h0600};
        vecs[7] = '{32'h0000_7000, 32'h5555_6666, 4'h8, 0, 0, 2, 8'h00, 2'b10, 2'b10, 16'h0008};
        vecs[8] = '{32'h0000_0007, 32'h7788_99AA, 4'h1, 1, 1, 0, 8'h00, 2'b00, 2'b00, 16'h0010};

        lite_n.awaddr = '0;
        lite_n.awprot = '0;
        lite_n.wdata  = '0;
        lite_n.wstrb  = '0;
        drive_idle();

        // Reset values while held in reset, then readies one edge after release.
        repeat (3) @(negedge clk);
        check_output("rst_lite_ready", {lite_n.awready, lite_n.wready, lite_n.bvalid, lite_n.bresp}, 5'b0);
        check_output("rst_axi_valid", {axi_n.awvalid, axi_n.wvalid, axi_n.bready}, 3'b0);
        rst_n = 1'b1;
        #1;
        check_output("rst_release_awready", lite_n.awready, 1'b0);
        @(posedge clk);
        #1;
        check_output("first_edge_awready", lite_n.awready, 1'b1);
        check_output("first_edge_wready", lite_n.wready, 1'b1);

        for (int i = 0; i < NUM_VECS; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Reset while the AXI write is outstanding abandons it at once.
        @(negedge clk);
        lite_n.awaddr  = 32'h0000_8000;
        lite_n.wdata   = 32'h0F0F_0F0F;
        lite_n.wstrb   = 4'hF;
        lite_n.awvalid = 1'b1;
        lite_n.wvalid  = 1'b1;
        @(negedge clk);
        lite_n.awvalid = 1'b0;
        lite_n.wvalid  = 1'b0;
        check_output("pre_rst_awvalid", axi_n.awvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_axi_valid", {axi_n.awvalid, axi_n.wvalid, axi_n.bready}, 3'b0);
        check_output("mid_rst_lite", {lite_n.awready, lite_n.wready, lite_n.bvalid}, 3'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("post_rst_awready", lite_n.awready, 1'b1);
        check_output("post_rst_awvalid", axi_w.awvalid, 1'b0);
        apply_stimulus('{32'h0000_9004, 32'h2468_ACE0, 4'hF, 0, 0, 1, 8'h00, 2'b00, 2'b00, 16'h00F0});

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
